// File: rtl/ast_pkg.sv
// ----------------------------------------------------------------------------
// ast_pkg
//   Shared definitions for the Avalon-ST store-and-forward packet buffer.
//   Contents:
//     state_t              - buffer FSM states (IDLE, RX, DROP, TX)
//     DEF_SYMBOLS_PER_BEAT - default bytes per beat, matches the sorter
//     ast_data_w()         - data width in bits derived from symbols per beat
// ----------------------------------------------------------------------------
package ast_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_DROP = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    localparam int DEF_SYMBOLS_PER_BEAT = 2;

    function automatic int ast_data_w(input int symbols);
        return 8 * symbols;
    endfunction

endpackage

// File: rtl/ast_buf_mem.sv
// ----------------------------------------------------------------------------
// ast_buf_mem
//   Simple dual-port packet RAM: one write port, one read port whose output
//   is registered (1-cycle latency). The read register only updates when
//   i_rd_en is high, so the output holds while the consumer stalls.
//   Ports:
//     i_clk      - clock
//     i_wr_en    - write strobe
//     i_wr_addr  - write word address
//     i_wr_data  - write data
//     i_rd_en    - load the read register from i_rd_addr
//     i_rd_addr  - read word address
//     o_rd_data  - registered read data
// ----------------------------------------------------------------------------
module ast_buf_mem #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ast_pkt_buffer.sv
// ----------------------------------------------------------------------------
// ast_pkt_buffer
//   Store-and-forward Avalon-ST packet buffer placed in front of the sorter.
//   One sop/eop-framed packet is captured, its framing and length checked,
//   and it is replayed gap-free on the source side only after eop arrives.
//
//   Ports:
//     clk        - single clock
//     srst_n     - synchronous reset, active low
//     snk_data   - upstream data            snk_valid - upstream valid
//     snk_sop    - upstream start of packet snk_eop   - upstream end of packet
//     snk_ready  - buffer can accept a beat (registered, low only in TX)
//     src_data   - replayed data            src_valid - replayed beat valid
//     src_sop    - first replayed word      src_eop   - last replayed word
//     src_ready  - sorter ready
//     pkt_len    - length of the packet being replayed, stable during TX
//     err        - one-cycle pulse on a framing or length error
//
//   Build option:
//     AST_PKT_BUF_DROP_EN - when defined, an oversize packet is dropped up to
//                           its eop; when undefined it is truncated to
//                           MAX_PKT_LEN words.
//
//   Handshake: a beat transfers on a rising edge where valid and ready are
//   both high. Source outputs (data/sop/eop/valid) hold while src_valid is
//   high and src_ready is low.
// ----------------------------------------------------------------------------
module ast_pkt_buffer
    import ast_pkg::*;
#(
    parameter  int SYMBOLS_PER_BEAT = DEF_SYMBOLS_PER_BEAT,
    parameter  int MAX_PKT_LEN      = 16,
    localparam int DATA_W           = ast_data_w(SYMBOLS_PER_BEAT),
    localparam int LEN_W            = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              err
);

    localparam int               AW        = $clog2(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    // FSM and write side
    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [LEN_W-1:0]   r_pkt_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_snk_ready;
    logic               w_acc;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;

    // Read side
    logic [LEN_W-1:0]   r_rd_cnt;
    logic               w_rd_load;
    logic               r_src_valid;
    logic               r_src_sop;
    logic               r_src_eop;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_acc     = snk_valid & r_snk_ready & srst_n;
    assign w_cnt_inc = r_cnt + ONE_C;

    // ------------------------------------------------------------------
    // FSM state register and write-side registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pkt_len   <= '0;
            r_err       <= 1'b0;
            r_snk_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pkt_len   <= w_len_nxt;
            r_err       <= w_err_nxt;
            // Registered from the next state so snk_ready tracks the state
            // without any path from snk_valid.
            r_snk_ready <= (w_state_nxt != ST_TX);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and write-port decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_pkt_len;
        w_err_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = '0;
        case (r_state)
            ST_IDLE, ST_DROP: begin
                if (w_acc) begin
                    if (snk_sop) begin
                        w_wr_en   = 1'b1;
                        w_cnt_nxt = ONE_C;
                        if (snk_eop) begin
                            w_len_nxt   = ONE_C;
                            w_state_nxt = ST_TX;
                        end else begin
                            w_state_nxt = ST_RX;
                        end
                    end else if (r_state == ST_IDLE) begin
                        // Stray beat outside a packet.
                        w_err_nxt = 1'b1;
                    end else if (snk_eop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RX: begin
                if (w_acc) begin
                    if (snk_sop) begin
                        // sop inside a packet: flag it and restart at word 0.
                        w_err_nxt = 1'b1;
                        w_wr_en   = 1'b1;
                        w_cnt_nxt = ONE_C;
                        if (snk_eop) begin
                            w_len_nxt   = ONE_C;
                            w_state_nxt = ST_TX;
                        end else begin
                            w_state_nxt = ST_RX;
                        end
`ifdef AST_PKT_BUF_DROP_EN
                    end else if (r_cnt == MAX_LEN_C) begin
                        // Buffer already full: the packet is oversize and
                        // is discarded through its eop.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = snk_eop ? ST_IDLE : ST_DROP;
`else
                    end else if (!snk_eop && (r_cnt == MAX_LEN_C - ONE_C)) begin
                        // Last free word without eop: close the packet here.
                        w_wr_en     = 1'b1;
                        w_wr_addr   = r_cnt[AW-1:0];
                        w_cnt_nxt   = MAX_LEN_C;
                        w_len_nxt   = MAX_LEN_C;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_TX;
`endif
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_cnt[AW-1:0];
                        w_cnt_nxt = w_cnt_inc;
                        if (snk_eop) begin
                            w_len_nxt   = w_cnt_inc;
                            w_state_nxt = ST_TX;
                        end
                    end
                end
            end
            ST_TX: begin
                if (r_src_valid && src_ready && r_src_eop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Replay: fetch the next word whenever the output register is empty
    // or being consumed this cycle. The RAM read register doubles as the
    // src_data output register.
    // ------------------------------------------------------------------
    assign w_rd_load = (r_state == ST_TX) && (!r_src_valid || src_ready) &&
                       (r_rd_cnt < r_pkt_len);

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_rd_cnt    <= '0;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end else if (r_state != ST_TX) begin
            r_rd_cnt    <= '0;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end else if (w_rd_load) begin
            r_rd_cnt    <= r_rd_cnt + ONE_C;
            r_src_valid <= 1'b1;
            r_src_sop   <= (r_rd_cnt == '0);
            r_src_eop   <= (r_rd_cnt == r_pkt_len - ONE_C);
        end else if (src_ready) begin
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end
    end

    ast_buf_mem #(
        .DEPTH (MAX_PKT_LEN),
        .WIDTH (DATA_W)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (snk_data),
        .i_rd_en   (w_rd_load),
        .i_rd_addr (r_rd_cnt[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign snk_ready = r_snk_ready;
    assign src_data  = w_rd_data;
    assign src_valid = r_src_valid;
    assign src_sop   = r_src_sop;
    assign src_eop   = r_src_eop;
    assign pkt_len   = r_pkt_len;
    assign err       = r_err;

endmodule

// File: tb/tb_ast_pkt_buffer.sv
// ----------------------------------------------------------------------------
// tb_ast_pkt_buffer
//   Directed bench for ast_pkt_buffer. Expected output beats, packed as
//   {sop, eop, pkt_len, data}, are queued as stimulus is driven and popped
//   by the output monitor on each src handshake.
// ----------------------------------------------------------------------------
module tb_ast_pkt_buffer;

  localparam int DATA_W      = 16;
  localparam int MAX_PKT_LEN = 16;
  localparam int LEN_W       = 5;
  localparam int EW          = DATA_W + 2 + LEN_W;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] snk_data  = '0;
  logic              snk_valid = 1'b0;
  logic              snk_sop   = 1'b0;
  logic              snk_eop   = 1'b0;
  logic              snk_ready;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;
  logic              src_ready = 1'b1;
  logic [LEN_W-1:0]  pkt_len;
  logic              err;

  ast_pkt_buffer #(
    .SYMBOLS_PER_BEAT (2),
    .MAX_PKT_LEN      (MAX_PKT_LEN)
  ) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_sop   (snk_sop),
    .snk_eop   (snk_eop),
    .snk_ready (snk_ready),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_ready (src_ready),
    .pkt_len   (pkt_len),
    .err       (err)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp   = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- src_ready pattern 1,0,0,1 ----------------
  logic       rdy_toggle = 1'b0;
  logic [3:0] rdy_pat    = 4'b1001;
  int         rdy_idx    = 0;

  always @(posedge clk) begin
    if (rdy_toggle) begin
      #1;
      src_ready = rdy_pat[rdy_idx];
      rdy_idx   = (rdy_idx + 1) % 4;
    end
  end

  // ---------------- output monitor ----------------
  logic              p_valid = 1'b0;
  logic              p_ready = 1'b0;
  logic              p_sop   = 1'b0;
  logic              p_eop   = 1'b0;
  logic [DATA_W-1:0] p_data  = '0;

  always @(negedge clk) begin
    if (!srst_n) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready)
        check("hold_stable", {src_valid, src_sop, src_eop, src_data},
              {1'b1, p_sop, p_eop, p_data});
      if (src_valid)
        check("snk_ready_in_tx", snk_ready, 0);
      if (src_valid && src_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("out_beat", {src_sop, src_eop, pkt_len, src_data}, exp_q.pop_front());
      end
      if (err) err_cnt++;
      p_valid = src_valid;
      p_ready = src_ready;
      p_sop   = src_sop;
      p_eop   = src_eop;
      p_data  = src_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                          input int len);
    exp_q.push_back({sop, eop, LEN_W'(len), d});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic sop, input logic eop);
    int budget;
    budget    = 200;
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    @(negedge clk);
    while (!snk_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("snk_accept_timeout", budget, 1);
    tick();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_exp(base + DATA_W'(i), i == 0, i == n - 1, n);
      send_beat(base + DATA_W'(i), i == 0, i == n - 1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 400;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !src_valid && snk_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_idle"}, {src_valid, snk_ready}, 2'b01);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int budget;

    tick();
    tick();
    srst_n = 1'b1;
    @(negedge clk);
    check("rst_src_valid", src_valid, 0);
    check("rst_src_sop",   src_sop,   0);
    check("rst_src_eop",   src_eop,   0);
    check("rst_err",       err,       0);
    check("rst_pkt_len",   pkt_len,   0);
    check("rst_snk_ready", snk_ready, 1);
    tick();

    // 4-word packet, latency and back-to-back streaming
    src_ready = 1'b1;
    send_pkt(16'h0001, 4);
    @(negedge clk);
    check("a_lat_not_yet", src_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a_stream_valid", src_valid, 1);
    end
    @(negedge clk);
    check("a_end_state", {src_valid, snk_ready}, 2'b01);
    check("a_all_popped", exp_q.size(), 0);
    tick();

    // one-beat packet
    send_pkt(16'hABCD, 1);
    wait_idle("b");

    // 3-word packet with src_ready toggling
    rdy_toggle = 1'b1;
    send_pkt(16'h00C0, 3);
    wait_idle("c");
    rdy_toggle = 1'b0;
    tick();
    src_ready = 1'b1;
    tick();

    // stray beat in IDLE, then sop inside a packet
    err_cnt = 0;
    send_beat(16'h0099, 1'b0, 1'b0);
    @(negedge clk);
    check("d_err_pulse", err, 1);
    @(negedge clk);
    check("d_err_single", err, 0);
    tick();
    send_beat(16'h0010, 1'b1, 1'b0);
    send_beat(16'h0011, 1'b0, 1'b0);
    send_pkt(16'h0020, 3);
    wait_idle("d");
    check("d_err_count", err_cnt, 2);

    // 20-word packet against MAX_PKT_LEN = 16
    err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
`ifndef AST_PKT_BUF_DROP_EN
      if (i < MAX_PKT_LEN)
        push_exp(16'h0100 + DATA_W'(i), i == 0, i == MAX_PKT_LEN - 1, MAX_PKT_LEN);
`endif
      send_beat(16'h0100 + DATA_W'(i), i == 0, i == 19);
    end
    repeat (4) tick();
    wait_idle("e");
`ifdef AST_PKT_BUF_DROP_EN
    check("e_err_count", err_cnt, 1);
`else
    check("e_err_count", err_cnt, 5);
`endif

    // reset in the middle of RX
    send_beat(16'h0055, 1'b1, 1'b0);
    send_beat(16'h0056, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    check("f_rx_rst_valid", src_valid, 0);
    check("f_rx_rst_ready", snk_ready, 1);
    check("f_rx_rst_len",   pkt_len,   0);
    tick();
    send_pkt(16'h0060, 3);
    wait_idle("f1");

    // reset in the middle of TX
    src_ready = 1'b0;
    send_pkt(16'h0070, 3);
    budget = 50;
    @(negedge clk);
    while (!src_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("f_tx_started", src_valid, 1);
    tick();
    do_reset();
    @(negedge clk);
    check("f_tx_rst_valid", src_valid, 0);
    check("f_tx_rst_ready", snk_ready, 1);
    check("f_tx_rst_sop",   src_sop,   0);
    tick();
    src_ready = 1'b1;
    send_pkt(16'h0080, 4);
    wait_idle("f2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
